// File: rtl/mul_result_serializer.sv
// mul_result_serializer: buffers 64-bit products and emits each as LO then HI word.
// Optional MUL_RESULT_OVF_EN adds in_signed/out_ovf per-entry overflow flag.
module mul_result_serializer #(
  parameter int DEPTH = 4,
  parameter int WW    = 32,
  parameter int PW    = 2 * WW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PW-1:0]            in_prod,
`ifdef MUL_RESULT_OVF_EN
  input  logic                     in_signed,
  output logic                     out_ovf,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WW-1:0]            out_word,
  output logic                     out_hi,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] mem_q [DEPTH];
  logic [PW-1:0] head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
`ifdef MUL_RESULT_OVF_EN
  logic ovf_q [DEPTH];
  logic ovf_d;
  assign ovf_d = in_signed ? (in_prod[PW-1:WW] != {WW{in_prod[WW-1]}}) : (in_prod[PW-1:WW] != '0);
  always_ff @(posedge clk)
    if (push) ovf_q[wr_ptr_q] <= ovf_d;
  assign out_ovf = out_valid && ovf_q[rd_ptr_q];
`endif
  assign in_ready = count_q != FULL;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == HI) && out_ready;
  assign count_d  = count_q + CW'(push) - CW'(pop);
  assign count    = count_q;
  assign head     = mem_q[rd_ptr_q];
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= in_prod;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  // Entering LO on count_d lets a fresh push surface on the very next cycle.
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE) ? ((count_d != '0) ? LO : IDLE) :
              (state_q == LO)   ? (out_ready ? HI : LO) :
              (out_ready ? ((count_d != '0) ? LO : IDLE) : HI);
  end
  always_comb begin
    out_valid = state_q != IDLE;
    out_hi    = state_q == HI;
    out_last  = state_q == HI;
    out_word  = (state_q == LO) ? head[WW-1:0] : (state_q == HI) ? head[PW-1:WW] : '0;
  end
endmodule

// File: tb/tb_mul_result_serializer.sv
// tb_mul_result_serializer: directed self-checking bench for mul_result_serializer.
module tb_mul_result_serializer;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_hi, out_last;
  logic [63:0] in_prod;
  logic [31:0] out_word;
  logic [2:0]  count;
`ifdef MUL_RESULT_OVF_EN
  logic in_signed, out_ovf;
`endif
  int checks = 0;
  int errors = 0;
  logic [63:0] p [4];
  logic [32:0] q [$];
  int count_m, pushed;
  logic push_e, pop_e;

  mul_result_serializer #(.DEPTH(4), .WW(32), .PW(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
`ifdef MUL_RESULT_OVF_EN
    .in_signed(in_signed), .out_ovf(out_ovf),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_hi(out_hi), .out_last(out_last), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chkc(input string tag, input logic [2:0] o, input logic [2:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic fill_drain;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_prod = p[k];
      tick;
    end
    in_prod = 64'hEEEE_EEEE_DDDD_DDDD;
    tick;
    in_valid = 1'b0;
    chk1("full_in_ready", in_ready, 1'b0);
    chkc("full_count", count, 3'd4);
    chk32("full_hold", out_word, p[0][31:0]);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk32("drain_lo", out_word, p[k][31:0]);
      chk1("drain_lo_hi", out_hi, 1'b0);
      tick;
      chk32("drain_hi", out_word, p[k][63:32]);
      chk1("drain_hi_last", out_last, 1'b1);
      if (k == 0) begin
        in_valid = 1'b1;
        in_prod  = 64'h9999_9999_8888_8888;
      end
      tick;
      in_valid = 1'b0;
      if (k == 0) chkc("full_pop_refuse", count, 3'd3);
    end
    chk1("drain_empty_valid", out_valid, 1'b0);
    chkc("drain_empty_count", count, 3'd0);
  endtask

`ifdef MUL_RESULT_OVF_EN
  task automatic ovf_case(input logic [63:0] prod, input logic sgn, input logic e);
    in_valid  = 1'b1;
    in_prod   = prod;
    in_signed = sgn;
    tick;
    in_valid  = 1'b0;
    chk1("ovf_lo", out_ovf, e);
    tick;
    chk1("ovf_hi", out_ovf, e);
    tick;
    chk1("ovf_idle", out_ovf, 1'b0);
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_prod = '0;
`ifdef MUL_RESULT_OVF_EN
    in_signed = 1'b0;
`endif
    tick;
    rst = 1'b0;
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chkc("rst_count", count, 3'd0);
    chk32("rst_word", out_word, 32'h0);
    chk1("rst_hi", out_hi, 1'b0);
    chk1("rst_last", out_last, 1'b0);

    in_valid = 1'b1; in_prod = 64'h0000_0001_FFFF_FFFE; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    chk1("single_valid", out_valid, 1'b1);
    chk32("single_lo", out_word, 32'hFFFF_FFFE);
    chk1("single_lo_hi", out_hi, 1'b0);
    chkc("single_count", count, 3'd1);
    tick;
    chk32("single_hi", out_word, 32'h0000_0001);
    chk1("single_hi_hi", out_hi, 1'b1);
    chk1("single_hi_last", out_last, 1'b1);
    tick;
    chk1("single_done_valid", out_valid, 1'b0);
    chkc("single_done_count", count, 3'd0);

    p[0] = 64'h1000_0001_2000_0001; p[1] = 64'h1000_0002_2000_0002;
    p[2] = 64'h1000_0003_2000_0003; p[3] = 64'h1000_0004_2000_0004;
    fill_drain;
    p[0] = 64'hA5A5_0000_5A5A_0000; p[1] = 64'hFFFF_FFFF_0000_0000;
    p[2] = 64'h0000_0000_FFFF_FFFF; p[3] = 64'h1234_5678_9ABC_DEF0;
    fill_drain;

    // Backpressure: out_ready toggles, pushes on even cycles, tracked by a word queue.
    count_m = 0; pushed = 0;
    for (int c = 0; c < 80; c++) begin
      if (pushed == 6 && q.size() == 0) break;
      out_ready = (c % 2) == 1;
      in_valid  = ((c % 2) == 0) && (pushed < 6);
      in_prod   = {32'hB000_0000 + 32'(pushed), 32'hA000_0000 + 32'(pushed)};
      chk1("bp_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk32("bp_word", out_word, q[0][31:0]);
        chk1("bp_hi", out_hi, q[0][32]);
      end
      chkc("bp_count", count, 3'(count_m));
      push_e = in_valid && (count_m != 4);
      pop_e  = (q.size() != 0) && out_ready && q[0][32];
      tick;
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (push_e) begin
        q.push_back({1'b0, in_prod[31:0]});
        q.push_back({1'b1, in_prod[63:32]});
        pushed++;
      end
      count_m = count_m + int'(push_e) - int'(pop_e);
    end
    in_valid = 1'b0;
    chk1("bp_end_valid", out_valid, 1'b0);
    chkc("bp_end_count", count, 3'd0);

    out_ready = 1'b1; in_valid = 1'b1;
    in_prod = 64'hAAAA_BBBB_CCCC_DDDD;
    tick;
    in_prod = 64'h1111_2222_3333_4444;
    tick;
    in_valid = 1'b0;
    chk32("mid_hi_word", out_word, 32'hAAAA_BBBB);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk1("mid_rst_valid", out_valid, 1'b0);
    chkc("mid_rst_count", count, 3'd0);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_prod = 64'h5;
    tick;
    in_valid = 1'b0;
    chk32("post_rst_lo", out_word, 32'h0000_0005);
    chk1("post_rst_lo_hi", out_hi, 1'b0);
    tick;
    chk32("post_rst_hi", out_word, 32'h0000_0000);
    chk1("post_rst_hi_hi", out_hi, 1'b1);
    tick;
    chk1("post_rst_idle", out_valid, 1'b0);

`ifdef MUL_RESULT_OVF_EN
    ovf_case(64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0);
    ovf_case(64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1);
    ovf_case(64'h0000_0001_0000_0000, 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_result_serializer.md
Name: mul_result_serializer

Overview:
- Downstream stage of the 32x32 multiplier; consumes its 64-bit product Z.
- Buffers products in a small FIFO and serializes each one onto the 32-bit ALU result bus as two words: low word first, then high word.
- Uses a valid/ready handshake on both sides, so the multiplier and the writeback path can run at different rates.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >=2
- PW, 64, product width; fixed at 2*WW
- WW, 32, output word width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  product offered
- in_ready  out  1  buffer can accept (= !full)
- in_prod  in  PW  product from multiplier (Z)
- out_valid  out  1  word presented
- out_ready  in  1  consumer accepts word
- out_word  out  WW  current word
- out_hi  out  1  0 = low half, 1 = high half
- out_last  out  1  last word of product (equals out_hi)
- count  out  $clog2(DEPTH)+1  entries held, including the one being drained

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Returns pointers, count and FSM to 0/IDLE.
  - Outputs after reset: out_valid=0, out_word=0, out_hi=0, out_last=0, count=0, in_ready=1.
  - Reset mid-operation discards all entries, including a half-sent product; the next product starts at its LO word.
- Push: in_valid && in_ready at edge N writes in_prod at the write pointer; write pointer wraps modulo DEPTH; count increments.
- in_ready = (count != DEPTH), a pure function of registered count.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - in_prod is ignored while in_ready=0.
- Latency: no bypass. A product pushed at edge N appears on out_word (LO) in cycle N+1 at the earliest.
- FSM states: IDLE, LO, HI.
  - IDLE: out_valid=0, out_word=0. Go to LO when count becomes >0.
  - LO: out_valid=1, out_word=head[WW-1:0], out_hi=0, out_last=0. On out_ready, go to HI.
  - HI: out_valid=1, out_word=head[PW-1:WW], out_hi=1, out_last=1. On out_ready:
    - pop the head (read pointer +1 mod DEPTH);
    - next state = LO if (count-1+push)>0, else IDLE.
- Push and pop in the same cycle: count is unchanged; both pointers advance.
- Backpressure: while out_valid && !out_ready, out_word, out_hi and out_last hold stable. Head entry contents are never overwritten while held.
- out_word and flags are decoded from registered state and the storage array; there is no combinational path from in_* to out_*.
- Word order is strict FIFO: products leave in push order, each as exactly LO then HI.

Optional Feature:
- Macro: MUL_RESULT_OVF_EN.
- When defined:
  - Adds input in_signed (1 bit, sampled with in_prod) and output out_ovf (1 bit).
  - Each entry stores an ovf bit computed at push:
    - signed: ovf = (in_prod[63:32] != {32{in_prod[31]}});
    - unsigned: ovf = (in_prod[63:32] != 0).
  - out_ovf is driven with both words of its product; 0 in IDLE and after reset.
- When undefined: in_signed and out_ovf ports are absent, entries are PW bits wide, and all other behaviour is identical.

Test Plan:
- Reset: assert rst for 1 cycle -> out_valid=0, in_ready=1, count=0, out_word=0.
- Single product: push 0x0000_0001_FFFF_FFFE, out_ready=1 -> next cycle out_word=0xFFFF_FFFE (hi=0); following cycle 0x0000_0001 (hi=1, last=1); then out_valid=0, count=0.
- Full and wrap: out_ready=0, push 4 products P0..P3 -> in_ready=0, count=4; attempted P4 is dropped. Release out_ready -> 8 words in order P0L,P0H..P3L,P3H. A second fill after the pointers wrap drains in the same order.
- Backpressure and concurrency: toggle out_ready 1/0 each cycle while pushing every other cycle -> out_word stable whenever out_ready=0; count unchanged on cycles with both push and HI pop; no word lost or duplicated.
- Reset mid-drain: push 0xAAAA_BBBB_CCCC_DDDD and 0x1111_2222_3333_4444, accept the first LO word, then assert rst -> buffer empty. Next push of 0x5 yields LO=0x0000_0005, then HI=0x0000_0000.
- With MUL_RESULT_OVF_EN:
  - signed 0xFFFF_FFFF_8000_0000 -> out_ovf=0;
  - signed 0xFFFF_FFFF_0000_0000 -> out_ovf=1;
  - unsigned 0x0000_0001_0000_0000 -> out_ovf=1 on both words.
